dm_port_arbiter: RTL and testbench

Shares the single data-memory port (`m_data_addr`/`m_data_byteen`/`m_data_wdata`/`m_data_rdata`) between the CPU memory stage and one burst-capable DMA requester. It sits between the memory stage's byte-enable and data-extension logic and the external memory. A DMA requester denied for too long may steal the port, so the block drives a stall to the pipeline's register write enables.

---
 rtl/dm_port_arbiter_if.sv | 43 ++++
 rtl/dm_port_arbiter.sv | 104 ++++++++++
 tb/tb_dm_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - CPU, DMA and memory-port signal bundle for dm_port_arbiter
interface dm_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_kill;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_last;
  logic [31:0] dma_addr;
  logic [3:0]  dma_byteen;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;

  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [31:0] m_data_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_kill, cpu_addr, cpu_byteen, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_last, dma_addr, dma_byteen, dma_wdata,
    output dma_gnt, dma_rdata,
    output m_data_addr, m_data_byteen, m_data_wdata,
    input  m_data_rdata
  );

  // Requesters plus external memory side.
  modport master (
    output cpu_req, cpu_kill, cpu_addr, cpu_byteen, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_last, dma_addr, dma_byteen, dma_wdata,
    input  dma_gnt, dma_rdata,
    input  m_data_addr, m_data_byteen, m_data_wdata,
    output m_data_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - shares the data-memory port between the CPU memory stage and a burst DMA
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  dm_port_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("dm_port_arbiter: STARVE_LIMIT out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("dm_port_arbiter: MAX_BURST out of range");
  end

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);
  localparam logic [4:0] BURST_LAST  = 5'(MAX_BURST - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [4:0]  beat_cnt_q, beat_cnt_d;

  logic cpu_eff;
  logic starved;
  logic burst_full;
  logic dma_gnt;

  assign cpu_eff    = bus.cpu_req & ~bus.cpu_kill;
  assign starved    = (starve_cnt_q == STARVE_LAST);
  assign burst_full = (beat_cnt_q == BURST_LAST);
  assign dma_gnt    = (state_q == S_DMA) & bus.dma_req;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_CPU: begin
        if (!bus.dma_req) begin
          starve_cnt_d = 4'd0;
        end else if (!cpu_eff || starved) begin
          state_d      = S_DMA;
          starve_cnt_d = 4'd0;
          beat_cnt_d   = 5'd0;
        end else begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      S_DMA: begin
        if (dma_gnt) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
        // All exit causes collapse into one return to the CPU.
        if (!bus.dma_req || (dma_gnt && (bus.dma_last || burst_full))) begin
          state_d    = S_CPU;
          beat_cnt_d = 5'd0;
        end
      end
      default: begin
        state_d      = S_CPU;
        starve_cnt_d = 4'd0;
        beat_cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_CPU;
      starve_cnt_q <= 4'd0;
      beat_cnt_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    bus.m_data_addr   = bus.cpu_addr;
    bus.m_data_byteen = bus.cpu_kill ? 4'h0 : bus.cpu_byteen;
    bus.m_data_wdata  = bus.cpu_wdata;
    bus.cpu_stall     = 1'b0;
    if (state_q == S_DMA) begin
      bus.m_data_addr   = bus.dma_addr;
      bus.m_data_byteen = bus.dma_byteen;
      bus.m_data_wdata  = bus.dma_wdata;
      // A killed access needs no freeze; the pipeline flushes it instead.
      bus.cpu_stall     = cpu_eff;
    end
  end

  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_rdata = bus.m_data_rdata;
  assign bus.dma_rdata = bus.m_data_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard bench for dm_port_arbiter with a word-addressed memory model
module tb_dm_port_arbiter;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [0:1023];
  assign bus.m_data_rdata = mem[bus.m_data_addr[11:2]];

  always @(posedge Clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.m_data_byteen[b] === 1'b1)
        mem[bus.m_data_addr[11:2]][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        gnt;
    logic        stall;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin : monitor
    exp_t  e;
    string t;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, ".gnt"},   {31'b0, bus.dma_gnt},    {31'b0, e.gnt});
      check_eq({t, ".stall"}, {31'b0, bus.cpu_stall},  {31'b0, e.stall});
      check_eq({t, ".addr"},  bus.m_data_addr,         e.addr);
      check_eq({t, ".be"},    {28'b0, bus.m_data_byteen}, {28'b0, e.be});
      if (e.chk_rd) begin
        check_eq({t, ".cpu_rdata"}, bus.cpu_rdata, e.rd);
        check_eq({t, ".dma_rdata"}, bus.dma_rdata, e.rd);
      end
    end
  end

  task automatic set_cpu(input logic req, input logic kill, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    bus.cpu_req    = req;
    bus.cpu_kill   = kill;
    bus.cpu_addr   = addr;
    bus.cpu_byteen = be;
    bus.cpu_wdata  = wdata;
  endtask

  task automatic set_dma(input logic req, input logic last, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    bus.dma_req    = req;
    bus.dma_last   = last;
    bus.dma_addr   = addr;
    bus.dma_byteen = be;
    bus.dma_wdata  = wdata;
  endtask

  // Record what this cycle must show, then advance to just after the next edge.
  task automatic step(input string tag, input logic eg, input logic es, input logic [31:0] ea,
                      input logic [3:0] eb, input bit crd = 1'b0, input logic [31:0] erd = 32'h0);
    exp_t e;
    e.gnt = eg; e.stall = es; e.addr = ea; e.be = eb; e.chk_rd = crd; e.rd = erd;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clk);
    #1;
  endtask

  int k;
  int bursts [3] = '{8, 8, 4};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    set_cpu(0, 0, 32'h44, 4'h0, 32'h0);
    set_dma(0, 0, 32'h0, 4'h0, 32'h0);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Reset state / both idle
    step("reset_idle", 0, 0, 32'h44, 4'h0);

    // CPU only: sw then lw
    set_cpu(1, 0, 32'h100, 4'hF, 32'h12345678);
    step("cpu_sw", 0, 0, 32'h100, 4'hF);
    set_cpu(1, 0, 32'h100, 4'h0, 32'h0);
    step("cpu_lw", 0, 0, 32'h100, 4'h0, 1'b1, 32'h12345678);

    // DMA 3-beat write while CPU idle
    set_cpu(0, 0, 32'h0, 4'h0, 32'h0);
    set_dma(1, 0, 32'h200, 4'hF, 32'hA0);
    step("dma_arb", 0, 0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      set_dma(1, (i == 2), 32'h200 + 4 * i, 4'hF, 32'hA0 + i);
      step("dma_beat", 1, 0, 32'h200 + 4 * i, 4'hF);
    end
    set_dma(0, 0, 32'h0, 4'h0, 32'h0);
    step("dma_back_cpu", 0, 0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 0, 32'h200 + 4 * i, 4'h0, 32'h0);
      step("dma_mem", 0, 0, 32'h200 + 4 * i, 4'h0, 1'b1, 32'hA0 + i);
    end

    // Kill in S_CPU suppresses the write
    set_cpu(1, 1, 32'h300, 4'hF, 32'hDEAD);
    step("kill_cpu", 0, 0, 32'h300, 4'h0);
    set_cpu(1, 0, 32'h300, 4'h0, 32'h0);
    step("kill_nowrite", 0, 0, 32'h300, 4'h0, 1'b1, 32'h0);

    // Kill in S_DMA drops the stall, beat proceeds
    set_cpu(0, 0, 32'h0, 4'h0, 32'h0);
    set_dma(1, 1, 32'h200, 4'h0, 32'h0);
    step("kdma_arb", 0, 0, 32'h0, 4'h0);
    set_cpu(1, 1, 32'h300, 4'hF, 32'hDEAD);
    step("kdma_beat", 1, 0, 32'h200, 4'h0, 1'b1, 32'hA0);
    set_cpu(0, 0, 32'h300, 4'h0, 32'h0);
    set_dma(0, 0, 32'h0, 4'h0, 32'h0);
    step("kdma_after", 0, 0, 32'h300, 4'h0, 1'b1, 32'h0);

    // Starvation: 20 beats, no last, CPU busy every cycle
    set_cpu(1, 0, 32'h400, 4'h0, 32'h0);
    k = 0;
    foreach (bursts[b]) begin
      for (int i = 0; i < 4; i++) begin
        set_dma(1, 0, 32'h500 + 4 * k, 4'hF, 32'hB000 + k);
        step("starve_deny", 0, 0, 32'h400, 4'h0);
      end
      for (int i = 0; i < bursts[b]; i++) begin
        set_dma(1, 0, 32'h500 + 4 * k, 4'hF, 32'hB000 + k);
        step("starve_gnt", 1, 1, 32'h500 + 4 * k, 4'hF);
        k++;
      end
    end
    set_dma(0, 0, 32'h500 + 4 * k, 4'h0, 32'h0);
    step("starve_drop", 0, 1, 32'h500 + 4 * k, 4'h0);
    step("starve_cpu", 0, 0, 32'h400, 4'h0);
    set_cpu(1, 0, 32'h500, 4'h0, 32'h0);
    step("starve_mem0", 0, 0, 32'h500, 4'h0, 1'b1, 32'hB000);
    set_cpu(1, 0, 32'h54C, 4'h0, 32'h0);
    step("starve_mem19", 0, 0, 32'h54C, 4'h0, 1'b1, 32'hB013);

    // Early drop after 2 beats; starvation count must restart
    set_cpu(1, 0, 32'h400, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_dma(1, 0, 32'h600, 4'hF, 32'hC000);
      step("drop_deny", 0, 0, 32'h400, 4'h0);
    end
    for (int i = 0; i < 2; i++) begin
      set_dma(1, 0, 32'h600 + 4 * i, 4'hF, 32'hC000 + i);
      step("drop_gnt", 1, 1, 32'h600 + 4 * i, 4'hF);
    end
    set_dma(0, 0, 32'h608, 4'h0, 32'h0);
    step("drop_fall", 0, 1, 32'h608, 4'h0);
    for (int i = 0; i < 4; i++) begin
      set_dma(1, 1, 32'h608, 4'hF, 32'hC002);
      step("drop_redeny", 0, 0, 32'h400, 4'h0);
    end
    step("drop_regnt", 1, 1, 32'h608, 4'hF);
    set_dma(0, 0, 32'h0, 4'h0, 32'h0);
    step("drop_end", 0, 0, 32'h400, 4'h0);

    // Reset mid-burst with beat_cnt = 3
    set_cpu(0, 0, 32'h700, 4'h0, 32'h0);
    set_dma(1, 0, 32'h800, 4'hF, 32'hD000);
    step("rst_arb", 0, 0, 32'h700, 4'h0);
    for (int i = 0; i < 3; i++) begin
      set_dma(1, 0, 32'h800 + 4 * i, 4'hF, 32'hD000 + i);
      step("rst_beat", 1, 0, 32'h800 + 4 * i, 4'hF);
    end
    set_cpu(1, 0, 32'h700, 4'h0, 32'h0);
    set_dma(1, 0, 32'h80C, 4'hF, 32'hD003);
    Rst = 1'b1;
    step("rst_cyc1", 1, 1, 32'h80C, 4'hF);
    step("rst_cyc2", 0, 0, 32'h700, 4'h0);
    Rst = 1'b0;
    step("rst_after", 0, 0, 32'h700, 4'h0);
    set_dma(0, 0, 32'h0, 4'h0, 32'h0);
    step("rst_idle", 0, 0, 32'h700, 4'h0);

    @(negedge Clk);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
